// File: rtl/systolic_feed_ctrl_if.sv
// systolic_feed_ctrl_if: operand-source and array-edge signal bundle for systolic_feed_ctrl
interface systolic_feed_ctrl_if #(
  parameter int N = 4,
  parameter int W = 8
);
  logic             i_start;
  logic [N*N*W-1:0] i_a;
  logic [N*N*W-1:0] i_b;
  logic [N*W-1:0]   o_row_a;
  logic [N*W-1:0]   o_col_b;
  logic             o_pe_clr;
  logic             o_busy;
  logic             o_done;
  modport master (
    output i_start, i_a, i_b,
    input  o_row_a, o_col_b, o_pe_clr, o_busy, o_done
  );
  modport slave (
    input  i_start, i_a, i_b,
    output o_row_a, o_col_b, o_pe_clr, o_busy, o_done
  );
endinterface

// File: rtl/systolic_feed_ctrl.sv
// systolic_feed_ctrl: captures A/B, clears PEs, feeds diagonally skewed operands, drains, pulses done
module systolic_feed_ctrl #(
  parameter int N     = 4,
  parameter int W     = 8,
  parameter int DRAIN = 4
) (
  input logic                 i_clk,
  input logic                 i_srst,
  systolic_feed_ctrl_if.slave bus
);
  localparam int CW = $clog2(2*N-1+DRAIN+1);
  localparam logic [CW-1:0] LAST_FEED = CW'(2*N-2);
  localparam logic [CW-1:0] LAST      = CW'(2*N-2+DRAIN);
  typedef enum logic [2:0] {IDLE, CLEAR, FEED, DRAINING, DONE} state_t;
  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [N*N*W-1:0] a_q, a_d, b_q, b_d;
  logic [N*W-1:0]   row_a, col_b;
  always_ff @(posedge i_clk) begin
    if (i_srst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
    end
  end
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (bus.i_start) begin
          state_d = CLEAR;
          a_d     = bus.i_a;
          b_d     = bus.i_b;
        end
      end
      CLEAR: begin
        state_d = FEED;
        cnt_d   = '0;
      end
      FEED: begin
        state_d = cnt_q == LAST_FEED ? (DRAIN == 0 ? DONE : DRAINING) : FEED;
        cnt_d   = cnt_q + 1'b1;
      end
      DRAINING: begin
        state_d = cnt_q == LAST ? DONE : DRAINING;
        cnt_d   = cnt_q + 1'b1;
      end
      DONE: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
      default: state_d = IDLE;
    endcase
  end
  always_comb begin
    row_a = '0;
    col_b = '0;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++)
        if (state_q == FEED && cnt_q == CW'(i + j)) begin
          row_a[i*W +: W] = a_q[(i*N+j)*W +: W];
          col_b[i*W +: W] = b_q[(j*N+i)*W +: W];
        end
  end
  assign bus.o_row_a  = row_a;
  assign bus.o_col_b  = col_b;
  assign bus.o_pe_clr = state_q == CLEAR;
  assign bus.o_busy   = state_q != IDLE;
  assign bus.o_done   = state_q == DONE;
endmodule

// File: doc/systolic_feed_ctrl.md
Name: systolic_feed_ctrl

Overview:
- Sequencer for an N x N output-stationary systolic array of 8-bit MAC processing elements.
- Captures one A matrix and one B matrix on a start request. Clears the PE accumulators, then drives the west edge (A rows) and north edge (B columns) with diagonally skewed operands.
- Waits for the array to drain, then pulses done.
- Sits between the operand source (host/buffer) and the array edge ports.

Parameters:
- N, 4, array dimension (rows = cols = N); legal 2..8
- W, 8, operand width in bits
- DRAIN, 4, idle cycles after last operand before done; default equals N (N-1 propagation hops + 1 accumulate register)

Ports:
- i_clk  input  1  clock, all state on rising edge
- i_srst  input  1  reset, synchronous, active-high
- i_start  input  1  start request; sampled only in IDLE
- i_a  input  N*N*W  matrix A, element (r,k) at bits [(r*N+k)*W +: W]
- i_b  input  N*N*W  matrix B, element (k,c) at bits [(k*N+c)*W +: W]
- o_row_a  output  N*W  west-edge operands, row r at bits [r*W +: W]
- o_col_b  output  N*W  north-edge operands, col c at bits [c*W +: W]
- o_pe_clr  output  1  accumulator clear to all PEs, one-cycle pulse
- o_busy  output  1  high whenever state != IDLE
- o_done  output  1  one-cycle completion pulse

Behaviour:
- Reset: state IDLE, feed counter 0, captured matrices 0. All outputs 0. Reset asserted in any state aborts the operation; the next cycle is IDLE with all outputs 0.
- FSM states and transitions:
  - IDLE: i_start=1 captures i_a/i_b into internal registers and moves to CLEAR. i_start=0 stays in IDLE.
  - CLEAR: 1 cycle, o_pe_clr=1, operands 0, then FEED with t=0.
  - FEED: 2N-1 cycles, t = 0..2N-2.
    - o_row_a[r] = A(r, t-r) if 0 <= t-r <= N-1, else 0.
    - o_col_b[c] = B(t-c, c) if 0 <= t-c <= N-1, else 0.
    - After t = 2N-2, moves to DRAIN.
  - DRAIN: DRAIN cycles with all operands 0, then DONE. DRAIN=0 goes FEED -> DONE directly.
  - DONE: 1 cycle, o_done=1, operands 0, then IDLE.
- Outputs are registered/state-decoded. No combinational path from i_start to any output.
- i_start while not IDLE (including DONE) is ignored and not queued. i_a/i_b changes after capture have no effect.
- Back-to-back runs: earliest restart is i_start in the first IDLE cycle after DONE.
- Total latency: from the i_start sample edge, o_done is high in cycle 1+1+(2N-1)+DRAIN, counting the start cycle as 0.
- Operands outside the skew window are exactly 0, so they contribute nothing to the PE accumulate.
- Counter width: clog2(2N-1+DRAIN+1). The counter does not wrap within a run.

Test Plan:
- Reset/idle: hold i_srst 3 cycles, then release with i_start=0 for 10 cycles -> o_row_a=o_col_b=0, o_pe_clr=o_busy=o_done=0 throughout.
- Skew pattern, N=2, DRAIN=2, A=[[1,2],[3,4]], B=[[5,6],[7,8]], i_start at cycle 0:
  - cycle 1: o_pe_clr=1
  - cycle 2 (t=0): row={1,0}, col={5,0}
  - cycle 3 (t=1): row={2,3}, col={7,6}
  - cycle 4 (t=2): row={0,4}, col={0,8}
  - cycles 5-6: all operands 0
  - cycle 7: o_done=1
  - cycle 8: o_busy=0
- End-to-end with 2x2 array of PEs, same matrices -> PE accumulators after done = [[19,22],[43,50]]. For N=4, A=identity, B=k*4+c+1 -> accumulators equal B.
- Start ignored when busy: pulse i_start at cycles 3 and 7 of the above run with different i_a -> operands and timing identical to the single-run trace, exactly one o_done, no second run.
- Reset mid-FEED: assert i_srst at t=1 -> next cycle IDLE, all outputs 0, no o_done. A subsequent i_start runs a full, correct sequence.
- Back-to-back: i_start held high continuously for N=2 -> runs begin at cycles 0 and 8. o_pe_clr at cycles 1 and 9, o_done at cycles 7 and 15.
